// File: rtl/timer_device.sv
// Bus-mapped millisecond timer: prescaler, up-counter with limit, and a
// control/status register (ready, overrun, interrupt enable).
module timer_device #(
    parameter int              BITS         = 32,
    parameter int              TICKS_PER_MS = 10000,
    parameter logic [BITS-1:0] TCNT_ADDR    = 32'hFFFFF100,
    parameter logic [BITS-1:0] TLIM_ADDR    = 32'hFFFFF104,
    parameter logic [BITS-1:0] TCTL_ADDR    = 32'hFFFFF108
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [BITS-1:0] ABUS,
    input  logic [BITS-1:0] DIN,
    input  logic            WE,
    output logic [BITS-1:0] DOUT,
    output logic            SEL,
    output logic            IRQ
);

    localparam int PW = (TICKS_PER_MS > 2) ? $clog2(TICKS_PER_MS) : 1;

    logic [PW-1:0]   r_presc;
    logic [BITS-1:0] r_tcnt;
    logic [BITS-1:0] r_tlim;
    logic            r_ready;
    logic            r_ovr;
    logic            r_ie;

    logic            w_tick;
    logic            w_hit_cnt;
    logic            w_hit_lim;
    logic            w_hit_ctl;
    logic            w_wr_cnt;
    logic            w_wr_lim;
    logic            w_wr_ctl;
    logic            w_event;
    logic [BITS-1:0] w_tctl;

    assign w_tick    = (r_presc == PW'(TICKS_PER_MS - 1));
    assign w_hit_cnt = (ABUS == TCNT_ADDR);
    assign w_hit_lim = (ABUS == TLIM_ADDR);
    assign w_hit_ctl = (ABUS == TCTL_ADDR);
    assign w_wr_cnt  = WE && w_hit_cnt;
    assign w_wr_lim  = WE && w_hit_lim;
    assign w_wr_ctl  = WE && w_hit_ctl;

    // Counter/limit writes pre-empt the tick, so they also suppress the limit event.
    assign w_event = w_tick && !w_wr_cnt && !w_wr_lim &&
                     (r_tlim != '0) && (r_tcnt == r_tlim - BITS'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_presc <= '0;
        end else if (w_wr_cnt || w_wr_lim || w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + PW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_tcnt <= '0;
            r_tlim <= '0;
        end else begin
            if (w_wr_lim) begin
                r_tlim <= DIN;
                r_tcnt <= '0;
            end else if (w_wr_cnt) begin
                r_tcnt <= DIN;
            end else if (w_event) begin
                r_tcnt <= '0;
            end else if (w_tick) begin
                r_tcnt <= r_tcnt + BITS'(1);
            end
        end
    end

    // A limit event overrides the write for ready/overrun; IE always follows the write.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ready <= 1'b0;
            r_ovr   <= 1'b0;
            r_ie    <= 1'b0;
        end else begin
            if (w_wr_ctl) begin
                r_ie <= DIN[4];
            end
            if (w_event) begin
                r_ready <= 1'b1;
                r_ovr   <= r_ovr | r_ready;
            end else if (w_wr_ctl) begin
                r_ready <= r_ready & DIN[0];
                r_ovr   <= r_ovr & DIN[2];
            end
        end
    end

    always_comb begin
        w_tctl    = '0;
        w_tctl[0] = r_ready;
        w_tctl[2] = r_ovr;
        w_tctl[4] = r_ie;
    end

    assign SEL = !WE && (w_hit_cnt || w_hit_lim || w_hit_ctl);
    assign IRQ = r_ready && r_ie;

    always_comb begin
        DOUT = '0;
        if (SEL) begin
            if (w_hit_cnt) begin
                DOUT = r_tcnt;
            end else if (w_hit_lim) begin
                DOUT = r_tlim;
            end else begin
                DOUT = w_tctl;
            end
        end
    end

endmodule
